// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback stage and register file
package wb_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_D = 2'b11
    } mem_size_e;

    // Access width in bytes for a load size code.
    function automatic logic [3:0] size_bytes(input mem_size_e size);
        case (size)
            MEM_B:   return 4'd1;
            MEM_H:   return 4'd2;
            MEM_W:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - load data byte-lane alignment and sign/zero extension
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] mem_rdata,
    input  mem_size_e       size,
    input  logic            is_unsigned,
    input  logic [2:0]      offset,
    output logic [XLEN-1:0] ext_data
);

    logic [2:0]      align_mask;
    logic [2:0]      eff_offset;
    logic [XLEN-1:0] shifted;

    // Round misaligned offsets down to the access size, shift the lane to bit 0, then extend.
    always_comb begin
        align_mask = 3'(size_bytes(size) - 4'd1);
        eff_offset = offset & ~align_mask;
        shifted    = mem_rdata >> {eff_offset, 3'b000};
        ext_data   = shifted;
        case (size)
            MEM_B:   ext_data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
            MEM_H:   ext_data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            MEM_W:   ext_data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage, register file with write bypass and forward tap (option WB_RETIRE_CNT_EN)
module wb_regfile
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [XLEN-1:0]   mem_rdata_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    input  logic [2:0]        mem_offset_in,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [63:0]       retired_count
);

    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   wb_data;
    logic              wr_en;

    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];
    logic              fwd_valid_q, fwd_valid_d;
    logic [REG_AW-1:0] fwd_rd_q, fwd_rd_d;
    logic [XLEN-1:0]   fwd_data_q, fwd_data_d;

    load_align u_load_align (
        .mem_rdata   (mem_rdata_in),
        .size        (mem_size_e'(mem_size_in)),
        .is_unsigned (mem_unsigned_in),
        .offset      (mem_offset_in),
        .ext_data    (load_data)
    );

    // Writeback source select and commit qualifier; x0 and reset cycles never write.
    always_comb begin
        wb_data = mem_to_reg_in ? load_data : alu_result_in;
        wr_en   = wb_valid_in & reg_write_in & (rd_in != '0) & ~reset;
    end

    // Read ports: x0 reads zero, a same-cycle write to the address is bypassed.
    always_comb begin
        if (rs1_addr == '0)                   rs1_data = '0;
        else if (wr_en && rs1_addr == rd_in)  rs1_data = wb_data;
        else                                  rs1_data = regs_q[rs1_addr];
        if (rs2_addr == '0)                   rs2_data = '0;
        else if (wr_en && rs2_addr == rd_in)  rs2_data = wb_data;
        else                                  rs2_data = regs_q[rs2_addr];
    end

    // Next state of the array and forward tap; reset overrides everything.
    always_comb begin
        regs_d      = regs_q;
        fwd_valid_d = wr_en;
        fwd_rd_d    = fwd_rd_q;
        fwd_data_d  = fwd_data_q;
        if (wr_en) begin
            regs_d[rd_in] = wb_data;
            fwd_rd_d      = rd_in;
            fwd_data_d    = wb_data;
        end
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_d[i] = '0;
            fwd_valid_d = 1'b0;
            fwd_rd_d    = '0;
            fwd_data_d  = '0;
        end
    end

    // Register array and forward tap state.
    always_ff @(posedge clk) begin
        regs_q      <= regs_d;
        fwd_valid_q <= fwd_valid_d;
        fwd_rd_q    <= fwd_rd_d;
        fwd_data_q  <= fwd_data_d;
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_rd    = fwd_rd_q;
    assign fwd_data  = fwd_data_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_q, retired_d;

    // Every valid WB instruction retires, whether or not it writes a register.
    always_comb begin
        retired_d = retired_q;
        if (reset)            retired_d = '0;
        else if (wb_valid_in) retired_d = retired_q + 64'd1;
    end

    // Retire counter state.
    always_ff @(posedge clk) begin
        retired_q <= retired_d;
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule
